// File: rtl/hart_pkg.sv
// Shared widths, defaults and refractory state encoding for the heart-rate front end.
package hart_pkg;

  localparam int HART_W = 6;
  localparam logic [HART_W-1:0] HART_MAX = 6'd63;

  localparam int WINDOW_DEF  = 1000;
  localparam int REFRACT_DEF = 200;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BLOCK = 1'b1;

  function automatic logic [HART_W-1:0] sat_inc(input logic [HART_W-1:0] v, input logic inc);
    return (inc && (v != HART_MAX)) ? v + 6'd1 : v;
  endfunction

endpackage

// File: rtl/hart_meter_beat_sync.sv
// Beat input conditioning: synchroniser, rising-edge detect and refractory lockout.
//   state    | meaning
//   ST_IDLE  | armed; next rising edge is accepted as a beat
//   ST_BLOCK | refractory window running; edges are dropped
module beat_sync
  import hart_pkg::*;
#(
  parameter int REFRACT = REFRACT_DEF
) (
  input  logic slow,
  input  logic reset,
  input  logic beat,
  output logic beat_ok
);

  localparam int RW = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RW-1:0] RLOAD = RW'(REFRACT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          sync_q3;
  logic [0:0]    state;
  logic [RW-1:0] rcnt;
  logic          rise;

  assign rise    = sync_q2 & ~sync_q3;
  assign beat_ok = rise && (state == ST_IDLE);

  always_ff @(posedge slow) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      sync_q3 <= 1'b0;
      state   <= ST_IDLE;
      rcnt    <= '0;
    end else begin
      sync_q1 <= beat;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;
      if (state == ST_IDLE) begin
        if (rise) begin
          state <= ST_BLOCK;
          rcnt  <= RLOAD;
        end
      end else begin
        // Edges arriving here are lost for good; only a fresh 0->1 re-arms.
        if (rcnt == '0) begin
          state <= ST_IDLE;
        end else begin
          rcnt <= rcnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hart_meter.sv
// Heart-rate meter: counts accepted beats per fixed window of slow cycles and
// publishes the saturated count with a one-cycle update strobe.
module hart_meter
  import hart_pkg::*;
#(
  parameter int WINDOW  = WINDOW_DEF,
  parameter int REFRACT = REFRACT_DEF
) (
  input  logic              slow,
  input  logic              reset,
  input  logic              beat,
  output logic [HART_W-1:0] hart,
  output logic              hart_upd,
  output logic              geen_hart
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);

  logic              beat_ok;
  logic [WW-1:0]     wcnt;
  logic [HART_W-1:0] bcnt;
  logic [HART_W-1:0] bnext;
  logic              close;

  beat_sync #(
    .REFRACT(REFRACT)
  ) u_beat_sync (
    .slow   (slow),
    .reset  (reset),
    .beat   (beat),
    .beat_ok(beat_ok)
  );

  assign close = (wcnt == LAST);
  // A beat accepted on the close cycle belongs to the closing window.
  assign bnext = sat_inc(bcnt, beat_ok);

  always_ff @(posedge slow) begin
    if (reset) begin
      wcnt      <= '0;
      bcnt      <= '0;
      hart      <= '0;
      hart_upd  <= 1'b0;
      geen_hart <= 1'b1;
    end else begin
      hart_upd <= close;
      if (close) begin
        wcnt      <= '0;
        bcnt      <= '0;
        hart      <= bnext;
        geen_hart <= (bnext == '0);
      end else begin
        wcnt <= wcnt + 1'b1;
        bcnt <= bnext;
      end
    end
  end

endmodule

// File: tb/tb_hart_meter.sv
// Directed bench for hart_meter: WINDOW=20/REFRACT=3 main instance plus a
// WINDOW=200/REFRACT=1 instance for saturation.
module tb_hart_meter;

  logic       slow = 1'b0;
  logic       reset;
  logic       beat;
  logic [5:0] hart;
  logic       hart_upd;
  logic       geen_hart;

  logic       reset2;
  logic       beat2;
  logic [5:0] hart2;
  logic       hart_upd2;
  logic       geen_hart2;

  int checks = 0;
  int passed = 0;
  int n;

  always #5 slow = ~slow;

  hart_meter #(.WINDOW(20), .REFRACT(3)) u_dut (
    .slow     (slow),
    .reset    (reset),
    .beat     (beat),
    .hart     (hart),
    .hart_upd (hart_upd),
    .geen_hart(geen_hart)
  );

  hart_meter #(.WINDOW(200), .REFRACT(1)) u_sat (
    .slow     (slow),
    .reset    (reset2),
    .beat     (beat2),
    .hart     (hart2),
    .hart_upd (hart_upd2),
    .geen_hart(geen_hart2)
  );

  task automatic tick();
    @(posedge slow);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pulses(input int cnt, input int hi, input int lo);
    for (int p = 0; p < cnt; p++) begin
      beat = 1'b1;
      repeat (hi) tick();
      beat = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic wait_upd(input int lim, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (hart_upd !== 1'b1 && cyc < lim);
  endtask

  initial begin
    reset  = 1'b1;
    beat   = 1'b0;
    reset2 = 1'b1;
    beat2  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state and empty windows
    chk("rst_hart", int'(hart), 0);
    chk("rst_upd", int'(hart_upd), 0);
    chk("rst_geen", int'(geen_hart), 1);
    wait_upd(40, n);
    chk("upd1_cyc", n, 20);
    chk("upd1_hart", int'(hart), 0);
    chk("upd1_geen", int'(geen_hart), 1);
    tick();
    chk("upd_one_cycle", int'(hart_upd), 0);
    wait_upd(40, n);
    chk("upd2_cyc", n, 19);
    wait_upd(40, n);
    chk("upd3_cyc", n, 20);

    // five clean pulses in one window
    pulses(5, 2, 2);
    chk("five_upd", int'(hart_upd), 1);
    chk("five_hart", int'(hart), 5);
    chk("five_geen", int'(geen_hart), 0);
    wait_upd(40, n);
    chk("empty_cyc", n, 20);
    chk("empty_hart", int'(hart), 0);
    chk("empty_geen", int'(geen_hart), 1);

    // bounce 1/0/1/0 gives one beat
    beat = 1'b1; tick();
    beat = 1'b0; tick();
    beat = 1'b1; tick();
    beat = 1'b0; tick();
    wait_upd(40, n);
    chk("bounce_cyc", n, 16);
    chk("bounce_hart", int'(hart), 1);

    // level held high gives one beat
    beat = 1'b1;
    repeat (15) tick();
    beat = 1'b0;
    wait_upd(40, n);
    chk("held_cyc", n, 5);
    chk("held_hart", int'(hart), 1);
    chk("held_geen", int'(geen_hart), 0);

    // beat accepted on the close cycle, then a blocked edge in the new window
    repeat (5) tick();
    pulses(2, 2, 2);
    repeat (4) tick();
    beat = 1'b1; tick();
    beat = 1'b0; tick();
    beat = 1'b1; tick();
    chk("close_upd", int'(hart_upd), 1);
    chk("close_hart", int'(hart), 3);
    chk("close_geen", int'(geen_hart), 0);
    beat = 1'b0;
    wait_upd(40, n);
    chk("after_close_cyc", n, 20);
    chk("after_close_hart", int'(hart), 0);
    chk("after_close_geen", int'(geen_hart), 1);

    // reset mid-window
    pulses(4, 2, 2);
    repeat (4) tick();
    chk("pre_rst_upd", int'(hart_upd), 1);
    chk("pre_rst_hart", int'(hart), 4);
    pulses(4, 2, 2);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("midrst_hart", int'(hart), 0);
    chk("midrst_upd", int'(hart_upd), 0);
    chk("midrst_geen", int'(geen_hart), 1);
    reset = 1'b0;
    pulses(2, 2, 2);
    wait_upd(40, n);
    chk("post_rst_cyc", n, 12);
    chk("post_rst_hart", int'(hart), 2);
    chk("post_rst_geen", int'(geen_hart), 0);

    // saturation on the fast-refractory instance
    reset2 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      n = 0;
      do begin
        beat2 = ~beat2;
        tick();
        n++;
      end while (hart_upd2 !== 1'b1 && n < 300);
      chk("sat_cyc", n, 200);
      chk("sat_hart", int'(hart2), 63);
      chk("sat_geen", int'(geen_hart2), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
